// File: rtl/seg_scan_capture_if.sv
// Scan-bus bundle for seg_scan_capture: the scanned digit/select lines from the
// transmitter, and the reassembled frame plus status pulses toward the consumer.
interface seg_scan_capture_if;
  logic [3:0]  Digit;
  logic [3:0]  Bit;
  logic [15:0] Word;
  logic        Valid;
  logic        Changed;
  logic        Err;
  logic        Locked;

  // Handshake: there is no back-pressure. Valid is a single-cycle strobe that
  // marks the cycle in which Word holds a freshly committed frame. Word stays
  // stable until the next Valid. Changed is only ever high together with Valid.
  modport master (
    output Digit, Bit,
    input  Word, Valid, Changed, Err, Locked
  );

  modport slave (
    input  Digit, Bit,
    output Word, Valid, Changed, Err, Locked
  );
endinterface

// File: rtl/seg_scan_capture.sv
// Reassembles a 16-bit display word from a multiplexed 7-segment scan bus.
// Optional macro SEG_CAPTURE_SYNC_EN adds 2-flop input synchronizers (+2 cycles latency).
module seg_scan_capture #(
  parameter int TIMEOUT = 16
) (
  input  logic               CLK,
  input  logic               RST,
  seg_scan_capture_if.slave  bus,
  output logic [1:0]         state_dbg
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    GOT0 = 2'd1,
    GOT1 = 2'd2,
    GOT2 = 2'd3
  } state_t;

  logic [3:0] bit_s;
  logic [3:0] digit_s;

`ifdef SEG_CAPTURE_SYNC_EN
  logic [3:0] bit_m_q, bit_s_q, digit_m_q, digit_s_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bit_m_q   <= 4'b1111;
      bit_s_q   <= 4'b1111;
      digit_m_q <= 4'h0;
      digit_s_q <= 4'h0;
    end else begin
      bit_m_q   <= bus.Bit;
      bit_s_q   <= bit_m_q;
      digit_m_q <= bus.Digit;
      digit_s_q <= digit_m_q;
    end
  end

  assign bit_s   = bit_s_q;
  assign digit_s = digit_s_q;
`else
  assign bit_s   = bus.Bit;
  assign digit_s = bus.Digit;
`endif

  state_t           state_q, state_d;
  logic [3:0]       prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      buf_q, buf_d;
  logic [15:0]      word_q, word_d;
  logic             valid_q, valid_d;
  logic             changed_q, changed_d;
  logic             err_q, err_d;
  logic             locked_q, locked_d;

  logic        sel_event;
  logic        sel_legal;
  logic [3:0]  exp_pat;
  logic        timeout_hit;
  logic [15:0] commit_word;

  assign sel_event   = (bit_s != prev_q);
  assign sel_legal   = (bit_s == 4'b1110) || (bit_s == 4'b1101) ||
                       (bit_s == 4'b1011) || (bit_s == 4'b0111);
  // Only no-event cycles count toward the timeout, so an event always wins.
  assign timeout_hit = !sel_event && (cnt_q == CNT_MAX - 1'b1);
  assign commit_word = {buf_q[15:4], digit_s};

  always_comb begin
    exp_pat = 4'b1110;
    case (state_q)
      HUNT: exp_pat = 4'b1110;
      GOT0: exp_pat = 4'b1101;
      GOT1: exp_pat = 4'b1011;
      GOT2: exp_pat = 4'b0111;
      default: exp_pat = 4'b1110;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= HUNT;
      prev_q    <= 4'b1111;
      cnt_q     <= '0;
      buf_q     <= 16'h0000;
      word_q    <= 16'h0000;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      err_q     <= err_d;
      locked_q  <= locked_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (sel_event) begin
      if (!sel_legal) begin
        state_d = HUNT;
      end else if (bit_s == exp_pat) begin
        case (state_q)
          HUNT: state_d = GOT0;
          GOT0: state_d = GOT1;
          GOT1: state_d = GOT2;
          GOT2: state_d = HUNT;
          default: state_d = HUNT;
        endcase
      end else if (state_q != HUNT && bit_s == 4'b1110) begin
        // Out-of-order digit 0 restarts the frame rather than discarding it.
        state_d = GOT0;
      end else begin
        state_d = HUNT;
      end
    end else if (timeout_hit) begin
      state_d = HUNT;
    end
  end

  always_comb begin
    prev_d    = bit_s;
    cnt_d     = sel_event ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);
    buf_d     = buf_q;
    word_d    = word_q;
    valid_d   = 1'b0;
    changed_d = 1'b0;
    err_d     = 1'b0;
    locked_d  = locked_q;
    if (sel_event) begin
      if (!sel_legal) begin
        err_d    = 1'b1;
        locked_d = 1'b0;
      end else if (bit_s == exp_pat) begin
        case (bit_s)
          4'b1110: buf_d[15:12] = digit_s;
          4'b1101: buf_d[11:8]  = digit_s;
          4'b1011: buf_d[7:4]   = digit_s;
          4'b0111: buf_d[3:0]   = digit_s;
          default: buf_d        = buf_q;
        endcase
        if (state_q == GOT2) begin
          word_d    = commit_word;
          valid_d   = 1'b1;
          changed_d = (commit_word != word_q);
          locked_d  = 1'b1;
        end
      end else if (state_q != HUNT) begin
        err_d    = 1'b1;
        locked_d = 1'b0;
        if (bit_s == 4'b1110) buf_d[15:12] = digit_s;
      end
    end else if (timeout_hit) begin
      locked_d = 1'b0;
    end
  end

  assign bus.Word    = word_q;
  assign bus.Valid   = valid_q;
  assign bus.Changed = changed_q;
  assign bus.Err     = err_q;
  assign bus.Locked  = locked_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture (default build): vector table,
// directed multi-cycle sequences, and randomized scans against a frame-level model.
`timescale 1ns/1ps
module tb_seg_scan_capture;
  localparam int TIMEOUT = 16;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] state_dbg;

  seg_scan_capture_if bus();

  seg_scan_capture #(.TIMEOUT(TIMEOUT)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int valid_seen = 0;
  int err_seen = 0;
  logic last_chg;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks how many digits of the current frame are in hand and the frame
  // nibbles themselves; outputs are what should be visible after the edge.
  int          m_have;
  logic [3:0]  m_nib[4];
  logic [15:0] m_word;
  logic        m_valid, m_changed, m_err, m_locked;
  logic [3:0]  m_prev;
  int          m_idle;

  function automatic int sel_pos(input logic [3:0] b);
    case (b)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_have = 0;
    for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
    m_word = 16'h0000;
    m_valid = 1'b0; m_changed = 1'b0; m_err = 1'b0; m_locked = 1'b0;
    m_prev = 4'b1111;
    m_idle = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [3:0] b, input logic [3:0] d);
    int p;
    logic [15:0] nw;
    m_valid = 1'b0; m_changed = 1'b0; m_err = 1'b0;
    if (b != m_prev) begin
      m_idle = 0;
      p = sel_pos(b);
      if (p < 0) begin
        m_err = 1'b1; m_locked = 1'b0; m_have = 0;
      end else if (p == m_have) begin
        m_nib[p] = d;
        if (p == 3) begin
          nw = {m_nib[0], m_nib[1], m_nib[2], m_nib[3]};
          m_valid = 1'b1;
          m_changed = (nw != m_word);
          m_word = nw;
          m_locked = 1'b1;
          m_have = 0;
          exp_q.push_back(nw);
        end else begin
          m_have = p + 1;
        end
      end else if (m_have != 0) begin
        m_err = 1'b1; m_locked = 1'b0;
        if (p == 0) begin m_nib[0] = d; m_have = 1; end
        else m_have = 0;
      end
    end else if (m_idle < TIMEOUT) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin m_have = 0; m_locked = 1'b0; end
    end
    m_prev = b;
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge; drives, lets one rising edge pass, compares, and
  // returns at the next falling edge.
  task automatic step(input logic [3:0] b, input logic [3:0] d);
    bus.Bit = b;
    bus.Digit = d;
    model_step(b, d);
    @(posedge CLK); #1;
    check("valid", {15'd0, bus.Valid}, {15'd0, m_valid});
    check("changed", {15'd0, bus.Changed}, {15'd0, m_changed});
    check("err", {15'd0, bus.Err}, {15'd0, m_err});
    check("locked", {15'd0, bus.Locked}, {15'd0, m_locked});
    check("word", bus.Word, m_word);
    if (bus.Err === 1'b1) err_seen++;
    if (bus.Valid === 1'b1) begin
      valid_seen++;
      last_chg = bus.Changed;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_word actual=%h required=no_commit", bus.Word);
      end else begin
        check("sb_word", bus.Word, exp_q.pop_front());
      end
    end
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    check("rst_word", bus.Word, 16'h0000);
    check("rst_valid", {15'd0, bus.Valid}, 16'd0);
    check("rst_changed", {15'd0, bus.Changed}, 16'd0);
    check("rst_err", {15'd0, bus.Err}, 16'd0);
    check("rst_locked", {15'd0, bus.Locked}, 16'd0);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  task automatic scan_frame(input logic [15:0] w, input int dwell);
    logic [3:0] one;
    logic [3:0] pat;
    logic [3:0] nib;
    one = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      pat = ~(one << k);
      nib = 4'(w >> (12 - 4 * k));
      for (int j = 0; j < dwell; j++) step(pat, nib);
    end
  endtask

  task automatic clear_counts();
    valid_seen = 0;
    err_seen = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  b;
    logic [3:0]  d;
    logic        v;
    logic        c;
    logic        e;
    logic        l;
    logic [15:0] w;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [15:0] rw;
    logic [3:0]  one;
    logic [3:0]  pat;
    int          dwell;

    tbl[0]  = '{4'b1110, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[1]  = '{4'b1101, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[2]  = '{4'b1011, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[3]  = '{4'b0111, 4'h4, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1234};
    tbl[4]  = '{4'b1110, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234};
    tbl[5]  = '{4'b1101, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234};
    tbl[6]  = '{4'b1011, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234};
    tbl[7]  = '{4'b0111, 4'h4, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234};
    tbl[8]  = '{4'b1110, 4'hB, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234};
    tbl[9]  = '{4'b0111, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234};
    tbl[10] = '{4'b1011, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234};
    tbl[11] = '{4'b1110, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234};
    tbl[12] = '{4'b1101, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234};
    tbl[13] = '{4'b1011, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234};
    tbl[14] = '{4'b0111, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0F0F};
    tbl[15] = '{4'b1111, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0F0F};

    RST = 1'b1;
    bus.Bit = 4'b1111;
    bus.Digit = 4'h0;
    last_chg = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);

    // Table: one-cycle dwell, in-order and out-of-order selects.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].b, tbl[i].d);
      check("tbl_valid", {15'd0, bus.Valid}, {15'd0, tbl[i].v});
      check("tbl_changed", {15'd0, bus.Changed}, {15'd0, tbl[i].c});
      check("tbl_err", {15'd0, bus.Err}, {15'd0, tbl[i].e});
      check("tbl_locked", {15'd0, bus.Locked}, {15'd0, tbl[i].l});
      check("tbl_word", bus.Word, tbl[i].w);
    end

    // 0x1234 with 3-cycle dwell, repeated, then 0xBEEF.
    do_reset();
    clear_counts();
    scan_frame(16'h1234, 3);
    check("f1234_valids", 16'(valid_seen), 16'd1);
    check("f1234_word", bus.Word, 16'h1234);
    check("f1234_changed", {15'd0, last_chg}, 16'd1);
    check("f1234_locked", {15'd0, bus.Locked}, 16'd1);
    check("f1234_errs", 16'(err_seen), 16'd0);
    clear_counts();
    scan_frame(16'h1234, 3);
    check("rep_valids", 16'(valid_seen), 16'd1);
    check("rep_changed", {15'd0, last_chg}, 16'd0);
    clear_counts();
    scan_frame(16'hBEEF, 3);
    check("beef_valids", 16'(valid_seen), 16'd1);
    check("beef_changed", {15'd0, last_chg}, 16'd1);
    check("beef_word", bus.Word, 16'hBEEF);

    // Start-up mid-frame: 1011, 0111 are ignored in HUNT.
    do_reset();
    clear_counts();
    repeat (3) step(4'b1011, 4'h7);
    repeat (3) step(4'b0111, 4'h8);
    check("midstart_errs", 16'(err_seen), 16'd0);
    check("midstart_valids", 16'(valid_seen), 16'd0);
    scan_frame(16'hA5C3, 2);
    check("a5c3_valids", 16'(valid_seen), 16'd1);
    check("a5c3_word", bus.Word, 16'hA5C3);
    check("a5c3_errs", 16'(err_seen), 16'd0);

    // Skipped digit after lock.
    clear_counts();
    repeat (2) step(4'b1110, 4'h1);
    repeat (2) step(4'b1101, 4'h2);
    repeat (2) step(4'b0111, 4'h4);
    check("skip_errs", 16'(err_seen), 16'd1);
    check("skip_locked", {15'd0, bus.Locked}, 16'd0);
    check("skip_valids", 16'(valid_seen), 16'd0);
    check("skip_word", bus.Word, 16'hA5C3);
    scan_frame(16'h1357, 2);
    check("relock_locked", {15'd0, bus.Locked}, 16'd1);
    check("relock_word", bus.Word, 16'h1357);

    // Timeout while holding 1101 mid-frame.
    clear_counts();
    step(4'b1110, 4'h9);
    step(4'b1101, 4'h9);
    repeat (TIMEOUT - 1) step(4'b1101, 4'h9);
    check("pre_timeout_locked", {15'd0, bus.Locked}, 16'd1);
    step(4'b1101, 4'h9);
    check("timeout_locked", {15'd0, bus.Locked}, 16'd0);
    check("timeout_errs", 16'(err_seen), 16'd0);
    check("timeout_word", bus.Word, 16'h1357);

    // Illegal two-hot select mid-frame, then 1101 is ignored in HUNT.
    scan_frame(16'h2468, 1);
    clear_counts();
    step(4'b1110, 4'h3);
    step(4'b1100, 4'h3);
    check("illegal_err", {15'd0, bus.Err}, 16'd1);
    check("illegal_locked", {15'd0, bus.Locked}, 16'd0);
    step(4'b1101, 4'h3);
    check("hunt_ignore_err", {15'd0, bus.Err}, 16'd0);

    // Reset after two digits discards the partial frame.
    step(4'b1110, 4'h6);
    step(4'b1101, 4'h6);
    do_reset();
    scan_frame(16'h0F0F, 2);
    check("post_rst_word", bus.Word, 16'h0F0F);

    // Randomized scans with corrupted, skipped and long-dwell digits.
    one = 4'b0001;
    for (int f = 0; f < 150; f++) begin
      rw = 16'($urandom);
      if ($urandom_range(0, 49) == 0) do_reset();
      if ($urandom_range(0, 9) == 0) repeat ($urandom_range(1, 3)) step(4'b1111, 4'h0);
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 19) == 0) continue;
        pat = ~(one << k);
        if ($urandom_range(0, 14) == 0) pat = 4'($urandom_range(0, 15));
        dwell = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 4)
                                            : $urandom_range(1, 4);
        for (int j = 0; j < dwell; j++) step(pat, 4'(rw >> (12 - 4 * k)));
      end
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover actual=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
